// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory-side responder.
// Optional Oor_Err trap output is enabled by defining SLC3_MEM_OOR_TRAP_EN.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RELEASE
    } mem_state_t;

    typedef logic [15:0] word_t;

    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned WAIT_W   = 4;

endpackage

// File: rtl/slc3_init_rom.sv
// Boot image for the SLC-3 RAM: a short program header followed by a fill pattern,
// zero beyond INIT_DEPTH.
module slc3_init_rom
    import slc3_mem_pkg::*;
#(
    parameter int unsigned INIT_DEPTH = 64,
    parameter int unsigned IDX_W      = 10
) (
    input  logic [IDX_W-1:0] idx_i,
    output word_t            word_o
);

    always_comb begin
        word_o = 16'h0000;
        if (32'(idx_i) < INIT_DEPTH) begin
            case (32'(idx_i))
                0:       word_o = 16'h5020;
                1:       word_o = 16'h1021;
                2:       word_o = 16'h2205;
                3:       word_o = 16'h3206;
                4:       word_o = 16'h0FFC;
                5:       word_o = 16'hF025;
                6:       word_o = 16'h00FF;
                7:       word_o = 16'hC1C0;
                default: word_o = 16'(idx_i) ^ 16'hA5A5;
            endcase
        end
    end

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: boots RAM from the init ROM, then serves OE/WE strobes with wait states.
// Define SLC3_MEM_OOR_TRAP_EN to add the sticky Oor_Err output.
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned INIT_DEPTH  = 64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] ADDR,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic        Init_Busy
`ifdef SLC3_MEM_OOR_TRAP_EN
    ,
    output logic        Oor_Err
`endif
);

    localparam int unsigned      Depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(INIT_DEPTH - 1);
    localparam logic [WAIT_W-1:0] WaitInit =
        (WAIT_CYCLES > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : WAIT_W'(WAIT_CYCLES);

    mem_state_t          state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   init_q, init_d;
    word_t               addr_q, addr_d;
    word_t               wdata_q, wdata_d;
    word_t               rdata_q, rdata_d;
    logic                ready_q, ready_d;

    word_t               ram [Depth];
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    word_t               ram_wdata;
    word_t               rom_word;
    logic [ADDR_W-1:0]   addr_idx;
    logic                oor;

    slc3_init_rom #(
        .INIT_DEPTH(INIT_DEPTH),
        .IDX_W     (ADDR_W)
    ) u_rom (
        .idx_i (init_q),
        .word_o(rom_word)
    );

    assign addr_idx = addr_q[ADDR_W-1:0];
    // Any set bit above the RAM index makes the latched address out of range.
    assign oor      = (addr_q >> ADDR_W) != 16'h0000;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        init_d    = init_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = init_q;
        ram_wdata = rom_word;
        unique case (state_q)
            INIT: begin
                ram_we = 1'b1;
                if (init_q == LastIdx) begin
                    init_d  = '0;
                    state_d = IDLE;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            IDLE: begin
                if (!WE) begin
                    addr_d  = ADDR;
                    wdata_d = Data_from_CPU;
                    wait_d  = WaitInit;
                    state_d = WR_WAIT;
                end else if (!OE) begin
                    addr_d  = ADDR;
                    wait_d  = WaitInit;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wait_q == '0) begin
                    rdata_d = oor ? 16'h0000 : ram[addr_idx];
                    ready_d = 1'b1;
                    state_d = RELEASE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            WR_WAIT: begin
                if (wait_q == '0) begin
                    ram_we    = !oor;
                    ram_waddr = addr_idx;
                    ram_wdata = wdata_q;
                    ready_d   = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RELEASE: begin
                if (OE && WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= INIT;
            wait_q  <= '0;
            init_q  <= '0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            init_q  <= init_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // RAM contents survive reset; the write port is gated so a reset edge never lands a write.
    always_ff @(posedge Clk) begin
        if (ram_we && Reset_n) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

`ifdef SLC3_MEM_OOR_TRAP_EN
    logic oor_err_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            oor_err_q <= 1'b0;
        end else if (ready_d && oor) begin
            oor_err_q <= 1'b1;
        end
    end

    assign Oor_Err = oor_err_q;
`endif

    assign Data_to_CPU = rdata_q;
    assign Ready       = ready_q;
    assign Init_Busy   = (state_q == INIT);

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder: directed cases plus randomized traffic
// against a word-array memory model.
module tb_slc3_mem_responder;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned WAIT_CYCLES = 1;
    localparam int unsigned INIT_DEPTH  = 64;
    localparam int unsigned LAT         = WAIT_CYCLES + 2;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] ADDR;
    logic        OE;
    logic        WE;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Ready;
    logic        Init_Busy;
`ifdef SLC3_MEM_OOR_TRAP_EN
    logic        Oor_Err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem   [1024];
    bit          valid [1024];
    logic [15:0] last_rd;
    bit          oor_seen;

    always #5 Clk = ~Clk;

    slc3_mem_responder #(
        .ADDR_W     (ADDR_W),
        .WAIT_CYCLES(WAIT_CYCLES),
        .INIT_DEPTH (INIT_DEPTH)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .ADDR         (ADDR),
        .OE           (OE),
        .WE           (WE),
        .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU  (Data_to_CPU),
        .Ready        (Ready),
        .Init_Busy    (Init_Busy)
`ifdef SLC3_MEM_OOR_TRAP_EN
        ,
        .Oor_Err      (Oor_Err)
`endif
    );

    function automatic logic [15:0] rom_word(int i);
        logic [15:0] hdr [8];
        hdr = '{16'h5020, 16'h1021, 16'h2205, 16'h3206, 16'h0FFC, 16'hF025, 16'h00FF, 16'hC1C0};
        if (i < 8) return hdr[i];
        return 16'(i) ^ 16'hA5A5;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_model();
        for (int i = 0; i < int'(INIT_DEPTH); i++) begin
            mem[i]   = rom_word(i);
            valid[i] = 1'b1;
        end
        last_rd  = 16'h0000;
        oor_seen = 1'b0;
    endtask

    // Counts cycles from reset release until Init_Busy drops; strobes are waved during boot.
    task automatic boot_check(input string tag);
        int k;
        Reset_n = 1'b1;
        OE      = 1'b0;
        WE      = 1'b1;
        ADDR    = 16'h0005;
        k = 0;
        while (Init_Busy === 1'b1 && k < 200) begin
            chk({tag, "_no_ready"}, 16'(Ready), 16'h0000);
            if (k == 20) WE = 1'b0;
            if (k == 40) begin
                OE = 1'b1;
                WE = 1'b1;
            end
            @(negedge Clk);
            k++;
        end
        chk({tag, "_busy_len"}, 16'(k), 16'(INIT_DEPTH));
        load_model();
    endtask

    // One full bus access starting at a negedge with the responder idle.
    task automatic access(input bit is_wr, input bit both, input logic [15:0] a,
                          input logic [15:0] d, input int hold);
        int          lat;
        bit          a_oor;
        logic [15:0] exp;
        a_oor         = (a >> ADDR_W) != 0;
        ADDR          = a;
        Data_from_CPU = d;
        WE            = is_wr ? 1'b0 : 1'b1;
        OE            = (!is_wr || both) ? 1'b0 : 1'b1;
        lat = 0;
        while (Ready !== 1'b1 && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        chk(is_wr ? "wr_latency" : "rd_latency", 16'(lat), 16'(LAT));
        if (is_wr) begin
            if (!a_oor) begin
                mem[a[ADDR_W-1:0]]   = d;
                valid[a[ADDR_W-1:0]] = 1'b1;
            end
        end else begin
            exp = a_oor ? 16'h0000 : mem[a[ADDR_W-1:0]];
            chk("rd_data", Data_to_CPU, exp);
            last_rd = exp;
        end
        oor_seen = oor_seen | a_oor;
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            chk("held_no_retrigger", 16'(Ready), 16'h0000);
        end
        OE = 1'b1;
        WE = 1'b1;
        @(negedge Clk);
        chk("ready_one_cycle", 16'(Ready), 16'h0000);
        chk("rd_data_hold", Data_to_CPU, last_rd);
`ifdef SLC3_MEM_OOR_TRAP_EN
        chk("oor_err", 16'(Oor_Err), 16'(oor_seen));
`endif
    endtask

    initial begin
        logic [15:0] ra;
        bit          wr;
        Reset_n       = 1'b0;
        OE            = 1'b1;
        WE            = 1'b1;
        ADDR          = 16'h0000;
        Data_from_CPU = 16'h0000;
        for (int i = 0; i < 1024; i++) valid[i] = 1'b0;

        #12;
        chk("rst_data", Data_to_CPU, 16'h0000);
        chk("rst_ready", 16'(Ready), 16'h0000);
        chk("rst_busy", 16'(Init_Busy), 16'h0001);
`ifdef SLC3_MEM_OOR_TRAP_EN
        chk("rst_oor_err", 16'(Oor_Err), 16'h0000);
`endif
        @(negedge Clk);
        boot_check("boot");

        for (int i = 0; i < int'(INIT_DEPTH); i++) access(1'b0, 1'b0, 16'(i), 16'h0000, 0);

        access(1'b1, 1'b0, 16'h0012, 16'hBEEF, 0);
        access(1'b0, 1'b0, 16'h0012, 16'h0000, 0);

        access(1'b1, 1'b1, 16'h0020, 16'h1234, 3);
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 0);

        access(1'b0, 1'b0, 16'hFC00, 16'h0000, 0);
        access(1'b1, 1'b0, 16'hFC12, 16'hDEAD, 0);
        access(1'b0, 1'b0, 16'h0012, 16'h0000, 0);

        access(1'b0, 1'b0, 16'h0020, 16'h0000, 8);
        access(1'b0, 1'b0, 16'h0012, 16'h0000, 0);

        for (int n = 0; n < 150; n++) begin
            ra = 16'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) ra = ra | (16'h0400 << $urandom_range(0, 5));
            wr = ($urandom_range(0, 1) == 1);
            if ((ra >> ADDR_W) == 0 && !valid[ra[ADDR_W-1:0]]) wr = 1'b1;
            access(wr, wr && ($urandom_range(0, 3) == 0), ra, 16'($urandom),
                   int'($urandom_range(0, 2)));
        end

        access(1'b1, 1'b0, 16'h0100, 16'h0A0A, 0);
        ADDR          = 16'h0100;
        Data_from_CPU = 16'h5555;
        WE            = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("abort_ready", 16'(Ready), 16'h0000);
        chk("abort_busy", 16'(Init_Busy), 16'h0001);
        chk("abort_data", Data_to_CPU, 16'h0000);
        WE = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_ready_hold", 16'(Ready), 16'h0000);
        boot_check("reboot");
        access(1'b0, 1'b0, 16'h0100, 16'h0000, 0);
        for (int i = 0; i < 8; i++) access(1'b0, 1'b0, 16'(i * 9), 16'h0000, 0);
        access(1'b0, 1'b0, 16'h0012, 16'h0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
